// File: rtl/sensor_frame_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sensor_frame_pkg
// Description : Shared constants and state encoding for sensor_frame_serializer.
//               Optional macro SENSOR_FRAME_SEQ_EN adds a sequence byte.
// Revision    : 1.0 - initial release
// ============================================================================
package sensor_frame_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         WORD_BITS         = 272;
    localparam int         PAYLOAD_BYTES     = 34;
    localparam int         HDR_BYTES_NOSEQ   = 2;
    localparam int         HDR_BYTES_SEQ     = 3;
    localparam int         FRAME_BYTES_NOSEQ = HDR_BYTES_NOSEQ + PAYLOAD_BYTES + 1;
    localparam int         FRAME_BYTES_SEQ   = HDR_BYTES_SEQ + PAYLOAD_BYTES + 1;
    localparam int         IDX_W             = 6;

`ifdef SENSOR_FRAME_SEQ_EN
    localparam int HDR_BYTES   = HDR_BYTES_SEQ;
    localparam int FRAME_BYTES = FRAME_BYTES_SEQ;
`else
    localparam int HDR_BYTES   = HDR_BYTES_NOSEQ;
    localparam int FRAME_BYTES = FRAME_BYTES_NOSEQ;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_LOAD = 2'd2,
        ST_SEND = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sensor_frame_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : sensor_frame_serializer_if
// Description : Parser-to-serializer handshake plus UART/busy status bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface sensor_frame_serializer_if;

    logic [271:0] sensor_iterations;
    logic         sensor_data_avl;
    logic         reset_parser;
    logic         tx;
    logic         busy;

    modport master (
        output sensor_iterations,
        output sensor_data_avl,
        input  reset_parser,
        input  tx,
        input  busy
    );

    modport slave (
        input  sensor_iterations,
        input  sensor_data_avl,
        output reset_parser,
        output tx,
        output busy
    );

endinterface
`default_nettype wire

// File: rtl/sensor_frame_serializer_uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : 8N1 LSB-first byte transmitter, CLK_DIV cycles per bit (>= 2).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte #(
    parameter int CLK_DIV = 625
) (
    input  wire logic       clk_72MHz,
    input  wire logic       reset,
    input  wire logic [7:0] byte_in,
    input  wire logic       byte_valid,
    output logic            byte_done,
    output logic            tx
);

    localparam int                BAUD_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [3:0]        STOP_BIT  = 4'd9;

    logic              active_q, active_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [3:0]        bit_q, bit_d;
    logic [9:0]        frame_q, frame_d;

    always_ff @(posedge clk_72MHz or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            baud_q   <= '0;
            bit_q    <= '0;
            frame_q  <= '0;
        end else begin
            active_q <= active_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            frame_q  <= frame_d;
        end
    end

    // The accept cycle already drives the start bit, so it counts as baud 0;
    // this lets a byte follow the previous stop bit with no idle gap.
    always_comb begin
        active_d  = active_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        frame_d   = frame_q;
        byte_done = 1'b0;
        if (!active_q) begin
            if (byte_valid) begin
                active_d = 1'b1;
                frame_d  = {1'b1, byte_in, 1'b0};
                baud_d   = BAUD_W'(1);
                bit_d    = 4'd0;
            end
        end else if (baud_q == BAUD_LAST) begin
            baud_d = '0;
            if (bit_q == STOP_BIT) begin
                active_d  = 1'b0;
                byte_done = 1'b1;
            end else begin
                bit_d   = bit_q + 4'd1;
                frame_d = {1'b1, frame_q[9:1]};
            end
        end else begin
            baud_d = baud_q + BAUD_W'(1);
        end
    end

    always_comb begin
        tx = 1'b1;
        if (active_q) begin
            tx = frame_q[0];
        end else if (byte_valid) begin
            tx = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sensor_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module      : sensor_frame_serializer
// Description : Captures a 272-bit parser word and sends it as a checksummed
//               UART frame. Macro SENSOR_FRAME_SEQ_EN adds a sequence byte.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_frame_serializer
    import sensor_frame_pkg::*;
#(
    parameter int         CLK_DIV   = 625,
    parameter logic [7:0] SENSOR_ID = 8'h00,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  wire logic                clk_72MHz,
    input  wire logic                reset,
    sensor_frame_serializer_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
    localparam logic [IDX_W-1:0] HDR_IDX  = IDX_W'(HDR_BYTES);

    state_e               state_q, state_d;
    logic [WORD_BITS-1:0] shadow_q, shadow_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [7:0]           csum_q, csum_d;
    logic                 reset_parser_q, reset_parser_d;
    logic                 busy_q, busy_d;
`ifdef SENSOR_FRAME_SEQ_EN
    logic [7:0]           seq_q, seq_d;
`endif

    logic [7:0]       payload [PAYLOAD_BYTES];
    logic [IDX_W-1:0] pay_idx;
    logic [7:0]       frame_byte;
    logic             byte_valid;
    logic             byte_done;

    // Payload byte 0 is the most significant byte of the shadow word.
    for (genvar k = 0; k < PAYLOAD_BYTES; k++) begin : g_payload
        assign payload[k] = shadow_q[WORD_BITS-1-8*k -: 8];
    end

    assign pay_idx = idx_q - HDR_IDX;

    always_comb begin
        frame_byte = payload[pay_idx];
        if (idx_q == '0) begin
            frame_byte = SYNC_BYTE;
        end else if (idx_q == IDX_W'(1)) begin
            frame_byte = SENSOR_ID;
`ifdef SENSOR_FRAME_SEQ_EN
        end else if (idx_q == IDX_W'(2)) begin
            frame_byte = seq_q;
`endif
        end else if (idx_q == LAST_IDX) begin
            frame_byte = csum_q;
        end
    end

    always_ff @(posedge clk_72MHz or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            shadow_q       <= '0;
            idx_q          <= '0;
            csum_q         <= '0;
            reset_parser_q <= 1'b0;
            busy_q         <= 1'b0;
`ifdef SENSOR_FRAME_SEQ_EN
            seq_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            shadow_q       <= shadow_d;
            idx_q          <= idx_d;
            csum_q         <= csum_d;
            reset_parser_q <= reset_parser_d;
            busy_q         <= busy_d;
`ifdef SENSOR_FRAME_SEQ_EN
            seq_q          <= seq_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        shadow_d       = shadow_q;
        idx_d          = idx_q;
        csum_d         = csum_q;
        reset_parser_d = reset_parser_q;
        busy_d         = busy_q;
`ifdef SENSOR_FRAME_SEQ_EN
        seq_d          = seq_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.sensor_data_avl) begin
                    shadow_d       = bus.sensor_iterations;
                    reset_parser_d = 1'b1;
                    busy_d         = 1'b1;
                    idx_d          = '0;
                    csum_d         = '0;
                    state_d        = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!bus.sensor_data_avl) begin
                    reset_parser_d = 1'b0;
                    state_d        = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Sync byte and the checksum byte itself stay out of the XOR.
                if ((idx_q != '0) && (idx_q != LAST_IDX)) begin
                    csum_d = csum_q ^ frame_byte;
                end
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (byte_done) begin
                    if (idx_q == LAST_IDX) begin
                        busy_d  = 1'b0;
                        idx_d   = '0;
                        csum_d  = '0;
`ifdef SENSOR_FRAME_SEQ_EN
                        seq_d   = seq_q + 8'd1;
`endif
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign byte_valid       = (state_q == ST_LOAD);
    assign bus.reset_parser = reset_parser_q;
    assign bus.busy         = busy_q;

    uart_tx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_uart_tx_byte (
        .clk_72MHz  (clk_72MHz),
        .reset      (reset),
        .byte_in    (frame_byte),
        .byte_valid (byte_valid),
        .byte_done  (byte_done),
        .tx         (bus.tx)
    );

endmodule
`default_nettype wire

// File: tb/tb_sensor_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sensor_frame_serializer
// Description : Self-checking bench: UART decoder plus frame reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sensor_frame_serializer;

    localparam int         D    = 4;
    localparam logic [7:0] ID   = 8'h03;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef SENSOR_FRAME_SEQ_EN
    localparam int FB  = 38;
    localparam int HDR = 3;
`else
    localparam int FB  = 37;
    localparam int HDR = 2;
`endif
    localparam int FRAME_CYC = FB * 10 * D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic [7:0] exp_frame[$];
    logic [7:0] got_frame[$];
    logic [7:0] exp_seq = 8'd0;

    typedef struct {
        logic [271:0] word;
        logic [7:0]   exp_first;
        logic [7:0]   exp_last;
        logic [7:0]   exp_csum;
    } vec_t;
    vec_t vecs[5];

    sensor_frame_serializer_if bus();

    sensor_frame_serializer #(
        .CLK_DIV   (D),
        .SENSOR_ID (ID),
        .SYNC_BYTE (SYNC)
    ) dut (
        .clk_72MHz (clk),
        .reset     (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // UART decoder: every bit must hold for exactly D cycles.
    initial begin : mon
        logic [9:0] bits;
        bit         steady;
        bit         aborted;
        int         t0;
        forever begin
            @(negedge clk);
            if (!rst && bus.tx === 1'b0) begin
                t0 = cyc; steady = 1'b1; aborted = 1'b0; bits = '0;
                for (int i = 0; i < 10 * D; i++) begin
                    if (i > 0) @(negedge clk);
                    if (rst) begin aborted = 1'b1; break; end
                    if (i % D == 0) bits[i / D] = bus.tx;
                    else if (bus.tx !== bits[i / D]) steady = 1'b0;
                end
                if (!aborted) begin
                    chk("uart_framing", {29'd0, steady, bits[0], bits[9]}, 32'h5);
                    rx_q.push_back(bits[8:1]);
                    rx_t.push_back(t0);
                end
            end
        end
    end

    task automatic make_expected(input logic [271:0] w);
        logic [7:0] cs;
        logic [7:0] b;
        exp_frame.delete();
        exp_frame.push_back(SYNC);
        exp_frame.push_back(ID);
        cs = ID;
`ifdef SENSOR_FRAME_SEQ_EN
        exp_frame.push_back(exp_seq);
        cs = cs ^ exp_seq;
`endif
        for (int k = 0; k < 34; k++) begin
            b = 8'(w >> (8 * (33 - k)));
            exp_frame.push_back(b);
            cs = cs ^ b;
        end
        exp_frame.push_back(cs);
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (rx_q.size() >= n) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (rx_q.size() >= n) ok = 1'b1;
    endtask

    task automatic start_word(input string name, input logic [271:0] w);
        bit seen;
        @(negedge clk);
        bus.sensor_iterations = w;
        bus.sensor_data_avl   = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            seen = bus.reset_parser;
        end
        chk({name, "_ack_seen"}, seen, 1);
        bus.sensor_data_avl = 1'b0;
    endtask

    task automatic check_frame(input string name);
        bit ok;
        bit gap_bad;
        wait_rx(FB, FRAME_CYC + 200, ok);
        chk({name, "_frame_timeout_ok"}, ok, 1);
        got_frame.delete();
        if (ok) begin
            gap_bad = 1'b0;
            for (int i = 0; i < FB; i++) begin
                chk($sformatf("%s_byte%0d", name, i), rx_q[i], exp_frame[i]);
                if (i > 0 && (rx_t[i] - rx_t[i-1]) != 10 * D) gap_bad = 1'b1;
            end
            chk({name, "_frame_len"}, rx_t[FB-1] - rx_t[0] + 10 * D, FRAME_CYC);
            chk({name, "_no_gaps"}, gap_bad, 0);
            for (int i = 0; i < FB; i++) begin
                got_frame.push_back(rx_q.pop_front());
                void'(rx_t.pop_front());
            end
            exp_seq = exp_seq + 8'd1;
        end else begin
            rx_q.delete();
            rx_t.delete();
        end
    endtask

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [271:0] w;
        logic [7:0]   seq_before;
        bit           seen;
        bit           rp_early;
        bit           ok;

        vecs[0] = '{272'h0, 8'h00, 8'h00, 8'h03};
        vecs[1] = '{{8'h12, 256'h0, 8'h34}, 8'h12, 8'h34, 8'h25};
        vecs[2] = '{{272{1'b1}}, 8'hFF, 8'hFF, 8'h03};
        w = '0;
        for (int k = 0; k < 34; k++) w = (w << 8) | 272'(k + 1);
        vecs[3] = '{w, 8'h01, 8'h22, 8'h20};
        vecs[4] = '{272'hC3 << 224, 8'h00, 8'h00, 8'hC0};

        bus.sensor_iterations = '0;
        bus.sensor_data_avl   = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_reset_parser", bus.reset_parser, 0);
        chk("rst_tx", bus.tx, 1);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_tx", bus.tx, 1);

        // Handshake timing
        make_expected(272'h0);
        bus.sensor_iterations = '0;
        bus.sensor_data_avl   = 1'b1;
        @(negedge clk);
        chk("hs_rp_rise", bus.reset_parser, 1);
        chk("hs_busy_rise", bus.busy, 1);
        repeat (4) @(negedge clk);
        chk("hs_rp_held", bus.reset_parser, 1);
        chk("hs_tx_idle_in_ack", bus.tx, 1);
        bus.sensor_data_avl = 1'b0;
        @(negedge clk);
        chk("hs_rp_release", bus.reset_parser, 0);
        chk("hs_busy_in_frame", bus.busy, 1);
        seen = (bus.tx == 1'b0);
        if (!seen) begin
            @(negedge clk);
            seen = (bus.tx == 1'b0);
        end
        chk("hs_start_latency", seen, 1);
        check_frame("hs");
        @(negedge clk);
        chk("hs_busy_fall", bus.busy, 0);

        // Table of hand-computed frames
        for (int v = 0; v < 5; v++) begin
            seq_before = exp_seq;
            make_expected(vecs[v].word);
            start_word($sformatf("vec%0d", v), vecs[v].word);
            check_frame($sformatf("vec%0d", v));
            if (got_frame.size() == FB) begin
                chk($sformatf("vec%0d_first", v), got_frame[HDR], vecs[v].exp_first);
                chk($sformatf("vec%0d_last", v), got_frame[FB-2], vecs[v].exp_last);
`ifdef SENSOR_FRAME_SEQ_EN
                chk($sformatf("vec%0d_csum", v), got_frame[FB-1], vecs[v].exp_csum ^ seq_before);
`else
                chk($sformatf("vec%0d_csum", v), got_frame[FB-1], vecs[v].exp_csum);
`endif
            end
        end

        // Random words against the model
        for (int r = 0; r < 8; r++) begin
            w = '0;
            for (int j = 0; j < 9; j++) w = (w << 32) | 272'($urandom);
            make_expected(w);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            start_word($sformatf("rnd%0d", r), w);
            check_frame($sformatf("rnd%0d", r));
        end

        // New word offered mid-frame must wait for the current frame
        w = {8'hDE, 256'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0_1122_3344, 8'hAD};
        make_expected(w);
        start_word("busyA", w);
        wait_rx(15, FRAME_CYC, ok);
        chk("busy_mid_reached", ok, 1);
        @(negedge clk);
        bus.sensor_iterations = ~w;
        bus.sensor_data_avl   = 1'b1;
        rp_early = 1'b0;
        for (int c = 0; c < FRAME_CYC && rx_q.size() < FB; c++) begin
            @(negedge clk);
            if (bus.reset_parser) rp_early = 1'b1;
        end
        chk("busy_rp_blocked", rp_early, 0);
        check_frame("busyA");
        make_expected(~w);
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            seen = bus.reset_parser;
        end
        chk("busyB_ack_seen", seen, 1);
        bus.sensor_data_avl = 1'b0;
        check_frame("busyB");

        // Reset during payload byte 10
        w = {34{8'h5A}};
        make_expected(w);
        start_word("rstmid", w);
        wait_rx(HDR + 10, FRAME_CYC, ok);
        chk("rstmid_reached", ok, 1);
        repeat (3 * D) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_tx", bus.tx, 1);
        chk("rstmid_rp", bus.reset_parser, 0);
        chk("rstmid_busy", bus.busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rx_q.delete();
        rx_t.delete();
        exp_seq = 8'd0;
        repeat (12 * D) @(negedge clk);
        chk("rstmid_abandoned", rx_q.size(), 0);
        chk("rstmid_line_idle", bus.tx, 1);
        w = {8'h77, 256'h0, 8'h99};
        make_expected(w);
        start_word("after_rst", w);
        check_frame("after_rst");

        repeat (20) @(negedge clk);
        chk("no_stray_bytes", rx_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
